// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a WIDTH-bit up/down counter: config handshake, run/pause/abort,
// terminal-count and one-shot completion pulses, and a fixed-length observation window after each start.
module counter_seq_ctrl #(
  parameter int WIDTH      = 4,
  parameter int WIN_CYCLES = 10,
  parameter int WIN_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_dir,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  input  logic             step_en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic             win_en
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   limit_q, limit_d;
  logic               dir_q, dir_d;
  logic               oneshot_q, oneshot_d;
  logic               tc_q, tc_d;
  logic               done_q, done_d;
  logic               win_en_q, win_en_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic               busy_q, busy_d;
  logic               cfg_ready_q, cfg_ready_d;

  logic               cfg_hs;
  logic [WIDTH-1:0]   load_limit;
  logic               load_dir;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   term_val;
  logic [WIDTH-1:0]   start_val;
  logic               win_start;

  // A config accepted in the same cycle as start must already drive the load value.
  always_comb begin
    cfg_hs     = cfg_valid && (state_q == S_IDLE);
    load_limit = cfg_hs ? cfg_limit : limit_q;
    load_dir   = cfg_hs ? cfg_dir : dir_q;
    load_val   = load_dir ? load_limit : '0;
    term_val   = dir_q ? '0 : limit_q;
    start_val  = dir_q ? limit_q : '0;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    limit_d   = limit_q;
    dir_d     = dir_q;
    oneshot_d = oneshot_q;
    tc_d      = 1'b0;
    done_d    = 1'b0;
    win_start = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_hs) begin
          limit_d   = cfg_limit;
          dir_d     = cfg_dir;
          oneshot_d = cfg_oneshot;
        end
        if (start && !stop) begin
          state_d   = S_RUN;
          count_d   = load_val;
          win_start = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_PAUSE;
        end else if (step_en) begin
          if (count_q == term_val) begin
            tc_d = 1'b1;
            if (oneshot_q) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              count_d = start_val;
            end
          end else if (dir_q) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Window runs for WIN_CYCLES clocks from a start out of IDLE; any return to IDLE cuts it short.
  always_comb begin
    win_en_d  = win_en_q;
    win_cnt_d = win_cnt_q;
    if (win_start) begin
      win_en_d  = 1'b1;
      win_cnt_d = '0;
    end else if (win_en_q) begin
      if ((state_d == S_IDLE) || (win_cnt_q == WIN_LAST)) begin
        win_en_d  = 1'b0;
        win_cnt_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
      end
    end
  end

  always_comb begin
    busy_d      = (state_d == S_RUN) || (state_d == S_PAUSE);
    cfg_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      limit_q     <= '0;
      dir_q       <= 1'b0;
      oneshot_q   <= 1'b0;
      tc_q        <= 1'b0;
      done_q      <= 1'b0;
      win_en_q    <= 1'b0;
      win_cnt_q   <= '0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      limit_q     <= limit_d;
      dir_q       <= dir_d;
      oneshot_q   <= oneshot_d;
      tc_q        <= tc_d;
      done_q      <= done_d;
      win_en_q    <= win_en_d;
      win_cnt_q   <= win_cnt_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign count     = count_q;
  assign busy      = busy_q;
  assign tc        = tc_q;
  assign done      = done_q;
  assign win_en    = win_en_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: every output checked after each edge against hand-computed values.
module tb_counter_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_limit;
  logic       cfg_dir;
  logic       cfg_oneshot;
  logic       start;
  logic       stop;
  logic       step_en;
  logic [3:0] count;
  logic       busy;
  logic       tc;
  logic       done;
  logic       win_en;

  int vectors = 0;
  int errs    = 0;

  logic [3:0] e1c [10];
  logic       e1t [10];
  logic       e1w [10];
  logic [3:0] e2c [5];

  counter_seq_ctrl #(.WIDTH(4), .WIN_CYCLES(10), .WIN_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_limit  (cfg_limit),
    .cfg_dir    (cfg_dir),
    .cfg_oneshot(cfg_oneshot),
    .start      (start),
    .stop       (stop),
    .step_en    (step_en),
    .count      (count),
    .busy       (busy),
    .tc         (tc),
    .done       (done),
    .win_en     (win_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input string sig, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s.%s observed=%0b expected=%0b", tag, sig, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] ec, input logic eb, input logic et,
                     input logic ed, input logic ew, input logic er);
    vectors++;
    assert (count === ec) else begin
      errs++;
      $error("FAIL %s.count observed=%0d expected=%0d", tag, count, ec);
    end
    chk1(tag, "busy", busy, eb);
    chk1(tag, "tc", tc, et);
    chk1(tag, "done", done, ed);
    chk1(tag, "win_en", win_en, ew);
    chk1(tag, "cfg_ready", cfg_ready, er);
  endtask

  task automatic offer_cfg(input logic [3:0] lim, input logic d, input logic os);
    cfg_valid   = 1'b1;
    cfg_limit   = lim;
    cfg_dir     = d;
    cfg_oneshot = os;
  endtask

  initial begin
    e1c = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2};
    e1t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    e1w = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    e2c = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

    reset = 1'b1; cfg_valid = 1'b0; cfg_limit = 4'd0; cfg_dir = 1'b0; cfg_oneshot = 1'b0;
    start = 1'b0; stop = 1'b0; step_en = 1'b0;
    tick();
    tick();
    chk("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    // Up free-run, limit 3, config and start in the same cycle
    offer_cfg(4'd3, 1'b0, 1'b0); start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("up_load", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("up_step%0d", i), e1c[i], 1'b1, e1t[i], 1'b0, e1w[i], 1'b0);
    end
    stop = 1'b1;
    tick();
    chk("up_pause", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("up_abort", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stop = 1'b0; step_en = 1'b0;

    // Down one-shot, limit 5, config separate from start
    offer_cfg(4'd5, 1'b1, 1'b1);
    tick();
    cfg_valid = 1'b0;
    chk("dn_cfg", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("dn_load", 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("dn_step%0d", i), e2c[i], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    tick();
    chk("dn_done", 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("dn_idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step_en = 1'b0;

    // limit 0 free-run: tc on every step, count stays 0
    offer_cfg(4'd0, 1'b0, 1'b0); start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("z_load", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step_en = 1'b1;
    tick();
    chk("z_step0", 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("z_step1", 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step_en = 1'b0; stop = 1'b1;
    tick();
    chk("z_pause", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("z_abort", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stop = 1'b0;

    // limit 0 one-shot: completes on first step
    offer_cfg(4'd0, 1'b0, 1'b1); start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("z1_load", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step_en = 1'b1;
    tick();
    chk("z1_done", 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("z1_idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step_en = 1'b0;

    // Up free-run limit 7: pause, resume without reload, start ignored in RUN
    offer_cfg(4'd7, 1'b0, 1'b0); start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("pr_load", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("pr_step%0d", k), 4'(k), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    stop = 1'b1;
    tick();
    chk("pr_pause", 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    stop = 1'b0;
    tick();
    chk("pr_hold", 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    chk("pr_resume", 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    chk("pr_run4", 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("pr_run5", 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    chk("pr_start_ign", 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b0; step_en = 1'b0; stop = 1'b1;
    tick();
    chk("pr_win_end", 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pr_abort", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // start+stop together in IDLE, then in RUN; abort cuts the window; restart gives a full one
    start = 1'b1;
    tick();
    chk("ss_idle", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stop = 1'b0;
    tick();
    chk("ss_load", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b0; step_en = 1'b1;
    tick();
    chk("ss_step", 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b1; stop = 1'b1;
    tick();
    chk("ss_run", 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    chk("ss_abort", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stop = 1'b0; step_en = 1'b0; start = 1'b1;
    tick();
    chk("win_restart", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      tick();
      chk($sformatf("win_c%0d", i), 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    tick();
    chk("win_off", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-RUN with a terminal step pending
    stop = 1'b1;
    tick();
    chk("rm_pause", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rm_abort", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stop = 1'b0;
    offer_cfg(4'd6, 1'b0, 1'b1); start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("rm_load", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("rm_step%0d", k), 4'(k), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    reset = 1'b1;
    tick();
    chk("rm_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0; step_en = 1'b0;
    tick();
    chk("rm_after", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
